reg_writeback_ctrl: RTL and testbench
=====================================

Name: reg_writeback_ctrl

Overview:
- Write-side initiator for the 32x32 register file.
- Accepts results from the ALU and load/store unit via valid/ready, buffers them in a small in-order queue, and drains one entry per cycle into the register file write port (wr_en/wr_addr/wr_data).
- Publishes a per-register pending scoreboard and youngest-value forwarding for the two read-address ports, so decode can check in-flight writes.

Parameters:
- DEPTH, 4, queue entries; power of two, at least 2.
- ADDR_W, 5, register address width.
- DATA_W, 32, register data width.

Ports:
- elk  in  1  clock; all state updates on posedge.
- nrst  in  1  asynchronous, active-high reset.
- alu_valid  in  1  ALU result offered.
- alu_addr  in  ADDR_W  ALU destination register.
- alu_data  in  DATA_W  ALU result.
- alu_ready  out  1  ALU result accepted this cycle when alu_valid is also high.
- mem_valid  in  1  load result offered.
- mem_addr  in  ADDR_W  load destination register.
- mem_data  in  DATA_W  load result.
- mem_ready  out  1  load result accepted this cycle when mem_valid is also high.
- wr_hold  in  1  stalls draining; no pop while high.
- wr_en  out  1  register-file write strobe (registered).
- wr_addr  out  ADDR_W  register-file write address (registered).
- wr_data  out  DATA_W  register-file write data (registered).
- pending  out  32  bit r is high when any in-flight entry targets register r.
- fwd_addrA  in  ADDR_W  read port A address to check.
- fwd_hitA  out  1  in-flight write to fwd_addrA exists.
- fwd_dataA  out  DATA_W  youngest in-flight data for fwd_addrA.
- fwd_addrB, fwd_hitB, fwd_dataB  same as the A signals, for read port B.

Behaviour:
- Reset (nrst high, asynchronous) sets:
  - queue count 0 and head/tail pointers 0;
  - wr_en 0, wr_addr 0, wr_data 0;
  - pending 0, fwd_hitA/fwd_hitB 0;
  - alu_ready and mem_ready forced to 0 for as long as nrst is high.
- Reset mid-operation discards all queued entries and the output stage. Nothing is written after reset is released.
- Ready and arbitration:
  - mem_ready = !full.
  - alu_ready = !full && !mem_valid (load has fixed priority).
  - At most one enqueue per edge.
- "full" means count == DEPTH as seen before the edge. No same-cycle pop credit is given to the producer.
- An accepted entry with address 0 is handshaked normally but never enqueued. pending[0] is always 0.
- Drain: on a posedge with count > 0 before the edge and wr_hold == 0:
  - pop the head into the output stage;
  - wr_en = 1 for that cycle, with wr_addr/wr_data = head.
- Otherwise wr_en = 0. wr_addr/wr_data hold their last values.
- No bypass: an entry enqueued at edge N can be popped at edge N+1 at the earliest. wr_en is therefore high in the cycle after edge N+1, and the register file captures it at edge N+2.
- Simultaneous push and pop: count unchanged, both pointers advance, and pointers wrap modulo DEPTH.
- Write ordering is strict FIFO. Equal-address entries retire in acceptance order.
- pending (combinational) = OR over valid queue entries plus the output stage while wr_en is high.
- Forwarding (combinational):
  - search order, youngest first: tail-1 down to head, then the output stage;
  - the first match supplies fwd_data;
  - address 0 never hits;
  - on a miss, fwd_data = 0.
- wr_hold high with a full queue: both ready outputs are 0 and state is frozen.

Decomposition:
- Package regwb_pkg holds:
  - ADDR_W/DATA_W constants;
  - REG_ZERO = 0;
  - typedef wb_entry_t {addr, data};
  - localparam NUM_REGS = 32.
- One sub-module, regwb_fifo: DEPTH-entry circular buffer of wb_entry_t, with push/pop, count, full/empty, and a flattened entry/valid view exported for the scoreboard and forwarding search.

Test Plan:
- Reset: hold nrst=1 with alu_valid=1 -> alu_ready=0, mem_ready=0, wr_en=0, pending=0. Release -> alu_ready=1 on the next cycle.
- Single write: alu (5, 0xDEADBEEF) accepted at edge N -> pending[5]=1 after N; wr_en=1, wr_addr=5, wr_data=0xDEADBEEF after N+1; pending[5]=0 after N+2.
- Contention: alu (3, 0x11) and mem (4, 0x22) both valid -> mem_ready=1, alu_ready=0, mem accepted first. ALU is held and accepted next cycle. Writes appear in order r4 then r3.
- Fill and wrap, with wr_hold=1:
  - push mem (1..4, 0xA1..0xA4) -> mem_ready=0 after the 4th push;
  - drop wr_hold while mem (6, 0xA6) is offered -> it is accepted only once count<4;
  - drain order is 1, 2, 3, 4, 6.
- Forwarding and r0:
  - with wr_hold=1, push (7, 0x1), (7, 0x2), (0, 0xFF) -> fwd_addrA=7 gives fwd_hitA=1, fwd_dataA=0x2;
  - fwd_addrB=0 gives fwd_hitB=0;
  - the queue holds 2 entries and no write to r0 ever occurs.
- Reset mid-operation: with 3 entries queued and wr_en high, pulse nrst between edges -> wr_en, pending and fwd_hitA/B drop immediately. No wr_en after release.

Source files
------------

// File: rtl/regwb_pkg.sv
// Shared types and constants for the register-file writeback controller.
package regwb_pkg;

  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned NUM_REGS = 32;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/regwb_fifo.sv
// Circular buffer of writeback entries; exports an age-ordered view (index 0 = oldest)
// so the parent can build the pending scoreboard and forwarding search.
module regwb_fifo
  import regwb_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  wb_entry_t             push_entry_i,
  input  logic                  pop_i,
  output wb_entry_t             pop_entry_o,
  output logic      [CntW-1:0]  count_o,
  output logic                  full_o,
  output logic                  empty_o,
  output wb_entry_t [DEPTH-1:0] entries_o,
  output logic      [DEPTH-1:0] valid_o
);

  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  logic      [PtrW-1:0]  head_q, head_d;
  logic      [PtrW-1:0]  tail_q, tail_d;
  logic      [CntW-1:0]  count_q, count_d;
  wb_entry_t [DEPTH-1:0] mem_q, mem_d;
  logic                  do_push, do_pop;

  assign full_o      = (count_q == DepthCnt);
  assign empty_o     = (count_q == '0);
  assign count_o     = count_q;
  assign pop_entry_o = mem_q[head_q];
  assign do_push     = push_i && !full_o;
  assign do_pop      = pop_i && !empty_o;

  // Pointer arithmetic wraps naturally because DEPTH is a power of two.
  always_comb begin
    mem_d  = mem_q;
    head_d = head_q;
    tail_d = tail_q;
    if (do_push) begin
      mem_d[tail_q] = push_entry_i;
      tail_d        = tail_q + PtrW'(1);
    end
    if (do_pop) begin
      head_d = head_q + PtrW'(1);
    end
    count_d = count_q + CntW'(do_push) - CntW'(do_pop);
  end

  always_comb begin
    entries_o = '0;
    valid_o   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entries_o[i] = mem_q[head_q + PtrW'(i)];
      valid_o[i]   = (CntW'(i) < count_q);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      mem_q   <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

endmodule

// File: rtl/reg_writeback_ctrl.sv
// Register-file write initiator: arbitrates ALU/load results into an in-order queue,
// drains one entry per cycle, and publishes pending bits and youngest-value forwarding.
module reg_writeback_ctrl #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = regwb_pkg::ADDR_W,
  parameter int unsigned DATA_W = regwb_pkg::DATA_W
) (
  input  logic                            elk,
  input  logic                            nrst,
  input  logic                            alu_valid,
  input  logic [ADDR_W-1:0]               alu_addr,
  input  logic [DATA_W-1:0]               alu_data,
  output logic                            alu_ready,
  input  logic                            mem_valid,
  input  logic [ADDR_W-1:0]               mem_addr,
  input  logic [DATA_W-1:0]               mem_data,
  output logic                            mem_ready,
  input  logic                            wr_hold,
  output logic                            wr_en,
  output logic [ADDR_W-1:0]               wr_addr,
  output logic [DATA_W-1:0]               wr_data,
  output logic [regwb_pkg::NUM_REGS-1:0]  pending,
  input  logic [ADDR_W-1:0]               fwd_addrA,
  output logic                            fwd_hitA,
  output logic [DATA_W-1:0]               fwd_dataA,
  input  logic [ADDR_W-1:0]               fwd_addrB,
  output logic                            fwd_hitB,
  output logic [DATA_W-1:0]               fwd_dataB
);

  import regwb_pkg::*;

  localparam int unsigned CntW = $clog2(DEPTH) + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  logic                  wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]     wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]     wr_data_q, wr_data_d;

  logic                  fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [CntW-1:0]       fifo_count;
  wb_entry_t             push_entry, head_entry, out_entry;
  wb_entry_t [DEPTH-1:0] entries;
  logic      [DEPTH-1:0] valid;
  logic                  mem_fire, alu_fire;
  logic [DATA_W:0]       fwd_a, fwd_b;

  // Loads have fixed priority; readiness never counts on a same-cycle pop.
  assign mem_ready = !nrst && !fifo_full;
  assign alu_ready = !nrst && !fifo_full && !mem_valid;
  assign mem_fire  = mem_valid && mem_ready;
  assign alu_fire  = alu_valid && alu_ready;

  always_comb begin
    push_entry.addr = mem_fire ? mem_addr : alu_addr;
    push_entry.data = mem_fire ? mem_data : alu_data;
  end

  // r0 writes complete the handshake but are dropped here.
  assign fifo_push = (mem_fire || alu_fire) && (push_entry.addr != REG_ZERO);
  assign fifo_pop  = !fifo_empty && !wr_hold;

  regwb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i        (elk),
    .rst_i        (nrst),
    .push_i       (fifo_push),
    .push_entry_i (push_entry),
    .pop_i        (fifo_pop),
    .pop_entry_o  (head_entry),
    .count_o      (fifo_count),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty),
    .entries_o    (entries),
    .valid_o      (valid)
  );

  always_comb begin
    wr_en_d   = fifo_pop;
    wr_addr_d = fifo_pop ? head_entry.addr : wr_addr_q;
    wr_data_d = fifo_pop ? head_entry.data : wr_data_q;
  end

  always_ff @(posedge elk or posedge nrst) begin
    if (nrst) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

  always_comb begin
    out_entry.addr = wr_addr_q;
    out_entry.data = wr_data_q;
  end

  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i]) pending[entries[i].addr] = 1'b1;
    end
    if (wr_en_q) pending[wr_addr_q] = 1'b1;
    pending[REG_ZERO] = 1'b0;
  end

  // Scan output stage first, then queue oldest to youngest; the last match is the youngest.
  function automatic logic [DATA_W:0] fwd_lookup(input logic [ADDR_W-1:0] addr);
    logic [DATA_W:0] res;
    res = '0;
    if (addr != REG_ZERO) begin
      if (wr_en_q && (out_entry.addr == addr)) res = {1'b1, out_entry.data};
      for (int i = 0; i < DEPTH; i++) begin
        if (valid[i] && (entries[i].addr == addr)) res = {1'b1, entries[i].data};
      end
    end
    return res;
  endfunction

  assign fwd_a     = fwd_lookup(fwd_addrA);
  assign fwd_b     = fwd_lookup(fwd_addrB);
  assign fwd_hitA  = fwd_a[DATA_W];
  assign fwd_dataA = fwd_a[DATA_W-1:0];
  assign fwd_hitB  = fwd_b[DATA_W];
  assign fwd_dataB = fwd_b[DATA_W-1:0];

  assert property (@(posedge elk) disable iff (nrst) fifo_count <= DepthCnt);

endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// Directed bench for reg_writeback_ctrl: expected writes go into a queue and a
// negedge monitor retires them against the register-file write port.
module tb_reg_writeback_ctrl;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 32;

  logic              elk = 1'b0;
  logic              nrst;
  logic              alu_valid, mem_valid, wr_hold;
  logic [ADDR_W-1:0] alu_addr, mem_addr, fwd_addrA, fwd_addrB;
  logic [DATA_W-1:0] alu_data, mem_data;
  logic              alu_ready, mem_ready, wr_en, fwd_hitA, fwd_hitB;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data, fwd_dataA, fwd_dataB;
  logic [31:0]       pending;

  int checks   = 0;
  int failures = 0;
  logic [ADDR_W+DATA_W-1:0] exp_q[$];

  always #5 elk = ~elk;

  reg_writeback_ctrl #(
    .DEPTH  (4),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) dut (
    .elk       (elk),
    .nrst      (nrst),
    .alu_valid (alu_valid),
    .alu_addr  (alu_addr),
    .alu_data  (alu_data),
    .alu_ready (alu_ready),
    .mem_valid (mem_valid),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .mem_ready (mem_ready),
    .wr_hold   (wr_hold),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .pending   (pending),
    .fwd_addrA (fwd_addrA),
    .fwd_hitA  (fwd_hitA),
    .fwd_dataA (fwd_dataA),
    .fwd_addrB (fwd_addrB),
    .fwd_hitB  (fwd_hitB),
    .fwd_dataB (fwd_dataB)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge elk);
    #1;
  endtask

  task automatic expect_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    exp_q.push_back({a, d});
  endtask

  // Monitor: every write strobe must match the oldest outstanding expectation.
  always @(negedge elk) begin
    if (!nrst && wr_en) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {31'b0, wr_en}, 32'd0);
      end else begin
        logic [ADDR_W+DATA_W-1:0] e;
        e = exp_q.pop_front();
        check("wr_addr", {27'b0, wr_addr}, {27'b0, e[ADDR_W+DATA_W-1:DATA_W]});
        check("wr_data", wr_data, e[DATA_W-1:0]);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    nrst      = 1'b1;
    wr_hold   = 1'b0;
    mem_valid = 1'b0;
    mem_addr  = '0;
    mem_data  = '0;
    alu_valid = 1'b1;
    alu_addr  = 5'd5;
    alu_data  = 32'hDEADBEEF;
    fwd_addrA = 5'd5;
    fwd_addrB = 5'd0;

    // Reset holds both readies low even with a pending offer.
    repeat (2) tick();
    check("rst_alu_ready", {31'b0, alu_ready}, 32'd0);
    check("rst_mem_ready", {31'b0, mem_ready}, 32'd0);
    check("rst_wr_en", {31'b0, wr_en}, 32'd0);
    check("rst_pending", pending, 32'd0);
    check("rst_fwd_hitA", {31'b0, fwd_hitA}, 32'd0);
    nrst = 1'b0;
    #1;
    check("rel_alu_ready", {31'b0, alu_ready}, 32'd1);

    // Single write: accepted at edge N.
    expect_wr(5'd5, 32'hDEADBEEF);
    tick();
    alu_valid = 1'b0;
    #1;
    check("single_pending_N", pending, 32'h0000_0020);
    check("single_wr_en_N", {31'b0, wr_en}, 32'd0);
    tick();
    check("single_wr_en_N1", {31'b0, wr_en}, 32'd1);
    check("single_wr_addr_N1", {27'b0, wr_addr}, 32'd5);
    check("single_pending_N1", pending, 32'h0000_0020);
    check("single_fwd_out", fwd_dataA, 32'hDEADBEEF);
    tick();
    check("single_wr_en_N2", {31'b0, wr_en}, 32'd0);
    check("single_pending_N2", pending, 32'd0);
    check("single_fwd_miss", {31'b0, fwd_hitA}, 32'd0);

    // Contention: load wins, ALU waits one cycle.
    alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'h11;
    mem_valid = 1'b1; mem_addr = 5'd4; mem_data = 32'h22;
    #1;
    check("cont_mem_ready", {31'b0, mem_ready}, 32'd1);
    check("cont_alu_ready", {31'b0, alu_ready}, 32'd0);
    expect_wr(5'd4, 32'h22);
    tick();
    mem_valid = 1'b0;
    #1;
    check("cont_alu_ready2", {31'b0, alu_ready}, 32'd1);
    expect_wr(5'd3, 32'h11);
    tick();
    alu_valid = 1'b0;
    repeat (3) tick();

    // Fill with hold, then wrap while a fifth load waits.
    wr_hold = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      mem_valid = 1'b1;
      mem_addr  = ADDR_W'(i);
      mem_data  = 32'hA0 + 32'(i);
      expect_wr(ADDR_W'(i), 32'hA0 + 32'(i));
      tick();
    end
    mem_addr = 5'd6;
    mem_data = 32'hA6;
    #1;
    check("full_mem_ready", {31'b0, mem_ready}, 32'd0);
    check("full_pending", pending, 32'h0000_001E);
    tick();
    check("hold_mem_ready", {31'b0, mem_ready}, 32'd0);
    check("hold_wr_en", {31'b0, wr_en}, 32'd0);
    check("hold_pending", pending, 32'h0000_001E);
    wr_hold = 1'b0;
    tick();
    check("drain_mem_ready", {31'b0, mem_ready}, 32'd1);
    check("drain_wr_en", {31'b0, wr_en}, 32'd1);
    check("drain_pending", pending, 32'h0000_001E);
    expect_wr(5'd6, 32'hA6);
    tick();
    mem_valid = 1'b0;
    #1;
    check("wrap_pending", pending, 32'h0000_005C);
    repeat (5) tick();

    // Forwarding picks the youngest r7; r0 is handshaked but dropped.
    wr_hold   = 1'b1;
    alu_valid = 1'b1; alu_addr = 5'd7; alu_data = 32'h1;
    expect_wr(5'd7, 32'h1);
    tick();
    alu_data = 32'h2;
    expect_wr(5'd7, 32'h2);
    tick();
    alu_addr = 5'd0; alu_data = 32'hFF;
    #1;
    check("r0_alu_ready", {31'b0, alu_ready}, 32'd1);
    tick();
    alu_valid = 1'b0;
    fwd_addrA = 5'd7;
    fwd_addrB = 5'd0;
    #1;
    check("fwd_hitA", {31'b0, fwd_hitA}, 32'd1);
    check("fwd_dataA", fwd_dataA, 32'h2);
    check("fwd_hitB_r0", {31'b0, fwd_hitB}, 32'd0);
    check("fwd_dataB_r0", fwd_dataB, 32'd0);
    check("fwd_pending", pending, 32'h0000_0080);
    wr_hold = 1'b0;
    tick();
    check("fwd_pop1_data", fwd_dataA, 32'h2);
    tick();
    check("fwd_out_hit", {31'b0, fwd_hitA}, 32'd1);
    check("fwd_out_data", fwd_dataA, 32'h2);
    tick();
    check("fwd_empty_hit", {31'b0, fwd_hitA}, 32'd0);
    check("fwd_empty_data", fwd_dataA, 32'd0);
    repeat (2) tick();

    // Reset mid-operation: three queued entries and a live write are discarded.
    wr_hold = 1'b1;
    for (int i = 9; i <= 12; i++) begin
      mem_valid = 1'b1;
      mem_addr  = ADDR_W'(i);
      mem_data  = 32'hB0 + 32'(i);
      tick();
    end
    mem_valid = 1'b0;
    fwd_addrA = 5'd10;
    fwd_addrB = 5'd12;
    expect_wr(5'd9, 32'hB9);
    wr_hold = 1'b0;
    tick();
    check("mid_wr_en", {31'b0, wr_en}, 32'd1);
    check("mid_fwd_hitA", {31'b0, fwd_hitA}, 32'd1);
    @(negedge elk);
    #1;
    nrst = 1'b1;
    #1;
    check("mid_rst_wr_en", {31'b0, wr_en}, 32'd0);
    check("mid_rst_pending", pending, 32'd0);
    check("mid_rst_hitA", {31'b0, fwd_hitA}, 32'd0);
    check("mid_rst_hitB", {31'b0, fwd_hitB}, 32'd0);
    check("mid_rst_mem_ready", {31'b0, mem_ready}, 32'd0);
    #1;
    nrst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("post_rst_wr_en", {31'b0, wr_en}, 32'd0);
    end
    check("post_rst_pending", pending, 32'd0);

    check("sb_left", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
